// File: rtl/aes_round_engine_if.sv
// Handshake and key-request bundle for aes_round_engine.
// master = block producer / key provider / result consumer, slave = engine.
// Valid/ready rule: a transfer happens on a rising edge where valid and ready
// are both 1; valid may not depend on ready, and data is held while valid
// is 1 and ready is 0.
`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif

interface aes_round_engine_if;
  logic                       Encrypt;
  logic                       In_valid;
  logic                       In_ready;
  logic [`AES_BLOCK_SIZE-1:0] Input_block;
  logic [3:0]                 Key_idx;
  logic                       Key_encrypt;
  logic [`AES_BLOCK_SIZE-1:0] Key;
  logic                       Out_valid;
  logic                       Out_ready;
  logic [`AES_BLOCK_SIZE-1:0] Output_block;

  modport master (
    output Encrypt, In_valid, Input_block, Key, Out_ready,
    input  In_ready, Key_idx, Key_encrypt, Out_valid, Output_block
  );

  modport slave (
    input  Encrypt, In_valid, Input_block, Key, Out_ready,
    output In_ready, Key_idx, Key_encrypt, Out_valid, Output_block
  );
endinterface

// File: rtl/aes_round_engine.sv
// Iterative AES round engine: one full round per clock, round keys fetched
// from an external provider through Key_idx/Key_encrypt.
// Decryption runs the equivalent inverse cipher, so both directions share the
// same SubBytes -> ShiftRows -> MixColumns -> AddRoundKey ordering.
// Optional feature: define AES_ROUND_ENGINE_ABORT_EN to add the Abort input.
`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif

module aes_round_engine #(
  parameter int KEY_SIZE = 128
) (
  input  logic               Clk,
  input  logic               Rst,
`ifdef AES_ROUND_ENGINE_ABORT_EN
  input  logic               Abort,
`endif
  aes_round_engine_if.slave  bus,
  output logic [1:0]         dbg_state
);

  localparam int NR_INT = (KEY_SIZE == 128) ? 10 :
                          (KEY_SIZE == 192) ? 12 :
                          (KEY_SIZE == 256) ? 14 : 0;
  localparam logic [3:0] NR = NR_INT[3:0];

  generate
    if (NR_INT == 0) begin : g_bad_key_size
      $error("aes_round_engine: KEY_SIZE must be 128, 192 or 256");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // ---------------- GF(2^8) and byte-level helpers ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
           {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  // Byte k of the block sits at bits [127-8k -: 8]; row = k%4, column = k/4.
  function automatic logic [127:0] sub_shift(input logic [127:0] s, input logic enc);
    logic [127:0] o;
    logic [7:0]   b;
    int           src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = enc ? (r + 4 * ((c + r) % 4)) : (r + 4 * ((c - r + 4) % 4));
        b   = s[127 - 8 * src -: 8];
        o[127 - 8 * (r + 4 * c) -: 8] = enc ? sbox(b) : inv_sbox(b);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic enc);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      if (enc) begin
        o[127 - 32 * c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        o[119 - 32 * c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        o[111 - 32 * c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        o[103 - 32 * c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end else begin
        o[127 - 32 * c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^
                               gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        o[119 - 32 * c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^
                               gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        o[111 - 32 * c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^
                               gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        o[103 - 32 * c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^
                               gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
    end
    return o;
  endfunction

  // ---------------- state ----------------
  state_t       state_q, state_d;
  logic [127:0] st_q;
  logic [3:0]   r_q;
  logic         dir_q;
  logic         out_valid_q;
  logic [127:0] out_block_q;

  logic         in_ready_c;
  logic         accept_c;
  logic         last_round_c;
  logic [3:0]   key_idx_c;
  logic         key_encrypt_c;
  logic [127:0] sub_c;
  logic [127:0] round_out_c;
  logic         abort;

`ifdef AES_ROUND_ENGINE_ABORT_EN
  assign abort = Abort;
`else
  assign abort = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, handshake and key-request decode; abort overrides everything.
  always_comb begin
    state_d       = state_q;
    in_ready_c    = 1'b0;
    last_round_c  = 1'b0;
    key_idx_c     = 4'd0;
    key_encrypt_c = bus.Encrypt;
    case (state_q)
      S_IDLE: begin
        in_ready_c = ~abort;
      end
      S_ROUND: begin
        key_idx_c     = r_q;
        key_encrypt_c = dir_q;
        last_round_c  = (r_q == NR);
        if (last_round_c) state_d = S_DONE;
      end
      S_DONE: begin
        in_ready_c = bus.Out_ready & ~abort;
        if (bus.Out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    accept_c = bus.In_valid & in_ready_c;
    if (accept_c) state_d = S_ROUND;
    if (abort)    state_d = S_IDLE;
  end

  // One AES round; the final round skips (Inv)MixColumns.
  always_comb begin
    sub_c       = sub_shift(st_q, dir_q);
    round_out_c = ((r_q == NR) ? sub_c : mix_cols(sub_c, dir_q)) ^ bus.Key;
  end

  // Datapath: initial AddRoundKey on accept, one round per ROUND cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      st_q        <= '0;
      r_q         <= 4'd0;
      dir_q       <= 1'b1;
      out_valid_q <= 1'b0;
      out_block_q <= '0;
    end else if (abort) begin
      out_valid_q <= 1'b0;
    end else begin
      if (accept_c) begin
        dir_q <= bus.Encrypt;
        st_q  <= bus.Input_block ^ bus.Key;
        r_q   <= 4'd1;
      end else if (state_q == S_ROUND) begin
        st_q <= round_out_c;
        if (!last_round_c) r_q <= r_q + 4'd1;
      end
      if (state_q == S_ROUND && last_round_c) begin
        out_block_q <= round_out_c;
        out_valid_q <= 1'b1;
      end else if (state_q == S_DONE && bus.Out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.In_ready     = in_ready_c;
  assign bus.Key_idx      = key_idx_c;
  assign bus.Key_encrypt  = key_encrypt_c;
  assign bus.Out_valid    = out_valid_q;
  assign bus.Output_block = out_block_q;
  assign dbg_state        = state_q;

endmodule
